// File: rtl/lr_shift_stream_pkg.sv
// Shared definitions for the left-right shifter stream stage: shift direction
// encoding and the width helper used to size shift-amount and level fields.
package lr_shift_stream_pkg;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } shift_dir_e;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 4;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/lr_shift_stream_if.sv
// Stream-side bundle of lr_shift_stream: command input, shifter head/result
// pair and registered result output, plus FIFO occupancy.
interface lr_shift_stream_if #(
   parameter int DATA_W = lr_shift_stream_pkg::DEF_DATA_W,
   parameter int DEPTH  = lr_shift_stream_pkg::DEF_DEPTH
);
   localparam int SH_W  = lr_shift_stream_pkg::clog2(DATA_W);
   localparam int LVL_W = lr_shift_stream_pkg::clog2(DEPTH) + 1;

   logic                            in_valid;
   logic                            in_ready;
   logic [DATA_W-1:0]               in_bits;
   logic [SH_W-1:0]                 in_shift;
   lr_shift_stream_pkg::shift_dir_e in_dir;

   logic [DATA_W-1:0]               sh_iBits;
   logic [SH_W-1:0]                 sh_shift;
   lr_shift_stream_pkg::shift_dir_e sh_dir;
   logic [DATA_W-1:0]               sh_oBits;

   logic                            out_valid;
   logic                            out_ready;
   logic [DATA_W-1:0]               out_bits;

   logic [LVL_W-1:0]                level;

   // slave is the stream block; master is whoever surrounds it (parent + shifter)
   modport slave (
      input  in_valid, in_bits, in_shift, in_dir, sh_oBits, out_ready,
      output in_ready, sh_iBits, sh_shift, sh_dir, out_valid, out_bits, level
   );

   modport master (
      output in_valid, in_bits, in_shift, in_dir, sh_oBits, out_ready,
      input  in_ready, sh_iBits, sh_shift, sh_dir, out_valid, out_bits, level
   );

endinterface

// File: rtl/lr_shift_cmd_fifo.sv
// Command FIFO holding {bits, shift, dir} entries; presents the head entry
// (or zeros/LEFT when empty) and tracks occupancy.
module lr_shift_cmd_fifo
   import lr_shift_stream_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [DATA_W-1:0]            i_bits,
   input  logic [clog2(DATA_W)-1:0]     i_shift,
   input  shift_dir_e                   i_dir,
   input  logic                         i_pop,
   output logic [DATA_W-1:0]            o_bits,
   output logic [clog2(DATA_W)-1:0]     o_shift,
   output shift_dir_e                   o_dir,
   output logic                         o_empty,
   output logic                         o_full,
   output logic [clog2(DEPTH):0]        o_level
);
   localparam int SH_W  = clog2(DATA_W);
   localparam int PTR_W = clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = DATA_W + SH_W + 1;

   logic [ENT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;

   logic             w_do_push;
   logic             w_do_pop;
   logic [ENT_W-1:0] w_head;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == LVL_W'(DEPTH));
   assign o_level   = r_level;
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_head    = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= {i_bits, i_shift, i_dir};
   end

   always_comb begin
      o_bits  = '0;
      o_shift = '0;
      o_dir   = LEFT;
      if (!o_empty) begin
         o_bits  = w_head[ENT_W-1 -: DATA_W];
         o_shift = w_head[SH_W:1];
         o_dir   = shift_dir_e'(w_head[0]);
      end
   end

endmodule

// File: rtl/lr_shift_stream.sv
// Streaming wrapper around an external combinational left-right shifter:
// queues commands, drives the shifter from the FIFO head, registers its result.
module lr_shift_stream
   import lr_shift_stream_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   lr_shift_stream_if.slave  s
);
   logic w_push;
   logic w_pop;
   logic w_empty;
   logic w_full;

   logic              r_vld_p1;
   logic [DATA_W-1:0] r_out_bits_p1;

   assign s.in_ready = !w_full;
   assign w_push     = s.in_valid && !w_full;
   assign w_pop      = !w_empty && (!r_vld_p1 || s.out_ready);

   lr_shift_cmd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_bits  (s.in_bits),
      .i_shift (s.in_shift),
      .i_dir   (s.in_dir),
      .i_pop   (w_pop),
      .o_bits  (s.sh_iBits),
      .o_shift (s.sh_shift),
      .o_dir   (s.sh_dir),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_level (s.level)
   );

   // Stage p1: capture the shifter's combinational result for the FIFO head
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1      <= 1'b0;
         r_out_bits_p1 <= '0;
      end else if (w_pop) begin
         r_vld_p1      <= 1'b1;
         r_out_bits_p1 <= s.sh_oBits;
      end else if (s.out_ready) begin
         r_vld_p1      <= 1'b0;
      end
   end

   assign s.out_valid = r_vld_p1;
   assign s.out_bits  = r_out_bits_p1;

endmodule

// File: tb/tb_lr_shift_stream.sv
// Directed bench for lr_shift_stream with a behavioural shifter wired on the
// sh_* / sh_oBits pair, as the parent would instantiate it.
module tb_lr_shift_stream;
   import lr_shift_stream_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   lr_shift_stream_if #(.DATA_W(8), .DEPTH(4)) bus ();

   lr_shift_stream #(.DATA_W(8), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .s   (bus)
   );

   // Stand-in for the neighbouring combinational shifter
   always_comb begin
      if (bus.sh_dir == RIGHT) bus.sh_oBits = bus.sh_iBits >> bus.sh_shift;
      else                     bus.sh_oBits = bus.sh_iBits << bus.sh_shift;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] b, input logic [2:0] sh, input logic d);
      bus.in_valid = v;
      bus.in_bits  = b;
      bus.in_shift = sh;
      bus.in_dir   = shift_dir_e'(d);
   endtask

   logic [7:0] bb_bits [3] = '{8'hF0, 8'h81, 8'hFF};
   logic [2:0] bb_sh   [3] = '{3'd4, 3'd1, 3'd7};
   logic       bb_dir  [3] = '{1'b1, 1'b0, 1'b1};
   logic [7:0] bb_exp  [3] = '{8'h0F, 8'h02, 8'h01};

   logic [7:0] bp_bits [5] = '{8'h3C, 8'h3C, 8'h01, 8'h80, 8'hA5};
   logic [2:0] bp_sh   [5] = '{3'd2, 3'd2, 3'd7, 3'd7, 3'd0};
   logic       bp_dir  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [7:0] bp_exp  [5] = '{8'hF0, 8'h0F, 8'h80, 8'h01, 8'hA5};

   logic [7:0] sp_bits [4] = '{8'h12, 8'h12, 8'h7E, 8'hC3};
   logic [2:0] sp_sh   [4] = '{3'd4, 3'd4, 3'd1, 3'd6};
   logic       sp_dir  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [7:0] sp_exp  [4] = '{8'h20, 8'h01, 8'h3F, 8'hC0};

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      tick();
      tick();
      rst = 1'b0;

      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_bits",  32'(bus.out_bits),  32'h00);
      chk("rst_level",     32'(bus.level),     32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_sh_iBits",  32'(bus.sh_iBits),  32'h00);
      chk("rst_sh_shift",  32'(bus.sh_shift),  32'd0);
      chk("rst_sh_dir",    32'(bus.sh_dir),    32'd0);

      // single command, 2-cycle latency
      drive(1'b1, 8'hB5, 3'd3, 1'b0);
      tick();
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      chk("single_sh_iBits", 32'(bus.sh_iBits),  32'hB5);
      chk("single_sh_shift", 32'(bus.sh_shift),  32'd3);
      chk("single_sh_dir",   32'(bus.sh_dir),    32'd0);
      chk("single_vld_early",32'(bus.out_valid), 32'd0);
      tick();
      chk("single_out_valid",32'(bus.out_valid), 32'd1);
      chk("single_out_bits", 32'(bus.out_bits),  32'hA8);
      chk("single_level",    32'(bus.level),     32'd0);
      tick();
      chk("single_drain",    32'(bus.out_valid), 32'd0);
      chk("single_hold_bits",32'(bus.out_bits),  32'hA8);

      // back-to-back at full throughput
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, bb_bits[i], bb_sh[i], bb_dir[i]);
         tick();
         if (i >= 1) begin
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b_bits",  32'(bus.out_bits),  32'(bb_exp[i-1]));
         end
      end
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      tick();
      chk("b2b_valid_last", 32'(bus.out_valid), 32'd1);
      chk("b2b_bits_last",  32'(bus.out_bits),  32'(bb_exp[2]));
      tick();
      chk("b2b_drain", 32'(bus.out_valid), 32'd0);

      // backpressure until full
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready_pre", 32'(bus.in_ready), 32'd1);
         drive(1'b1, bp_bits[i], bp_sh[i], bp_dir[i]);
         tick();
      end
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      chk("bp_level_full", 32'(bus.level),     32'd4);
      chk("bp_in_ready",   32'(bus.in_ready),  32'd0);
      chk("bp_valid",      32'(bus.out_valid), 32'd1);
      chk("bp_held_bits",  32'(bus.out_bits),  32'(bp_exp[0]));
      drive(1'b1, 8'h55, 3'd1, 1'b0);
      tick();
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      tick();
      chk("bp_full_ignore", 32'(bus.level),    32'd4);
      chk("bp_stable_bits", 32'(bus.out_bits), 32'(bp_exp[0]));
      bus.out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_drain_bits",  32'(bus.out_bits),  32'(bp_exp[i]));
         chk("bp_in_ready_rel",32'(bus.in_ready),  32'd1);
      end
      tick();
      chk("bp_end_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_end_level", 32'(bus.level),     32'd0);

      // simultaneous push and pop at level 2
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, sp_bits[i], sp_sh[i], sp_dir[i]);
         tick();
      end
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      chk("sp_level2", 32'(bus.level), 32'd2);
      tick();
      chk("sp_stall_bits",  32'(bus.out_bits), 32'(sp_exp[0]));
      chk("sp_stall_level", 32'(bus.level),    32'd2);
      drive(1'b1, sp_bits[3], sp_sh[3], sp_dir[3]);
      bus.out_ready = 1'b1;
      tick();
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      chk("sp_level_same", 32'(bus.level),    32'd2);
      chk("sp_bits1",      32'(bus.out_bits), 32'(sp_exp[1]));
      for (int i = 2; i < 4; i++) begin
         tick();
         chk("sp_order", 32'(bus.out_bits), 32'(sp_exp[i]));
      end
      tick();
      chk("sp_end_valid", 32'(bus.out_valid), 32'd0);

      // reset mid-stream
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, bp_bits[i], bp_sh[i], bp_dir[i]);
         tick();
      end
      chk("mrst_pre_level", 32'(bus.level),     32'd3);
      chk("mrst_pre_valid", 32'(bus.out_valid), 32'd1);
      drive(1'b1, 8'h99, 3'd2, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      chk("mrst_valid",    32'(bus.out_valid), 32'd0);
      chk("mrst_bits",     32'(bus.out_bits),  32'h00);
      chk("mrst_level",    32'(bus.level),     32'd0);
      chk("mrst_in_ready", 32'(bus.in_ready),  32'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
      end

      // empty idle with noise on the input data lines
      drive(1'b0, 8'hE7, 3'd5, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_sh_iBits", 32'(bus.sh_iBits),  32'h00);
         chk("idle_sh_shift", 32'(bus.sh_shift),  32'd0);
         chk("idle_sh_dir",   32'(bus.sh_dir),    32'd0);
         chk("idle_valid",    32'(bus.out_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
